// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: datapath widths, reset PC, opcode constants
// and the {instr, pc} payload carried through the skid buffer.
package fetch_stage_pkg;

    localparam int unsigned PC_WIDTH       = 16;
    localparam int unsigned INSTR_WIDTH    = 32;
    localparam int unsigned OPCODE_WIDTH   = 6;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(0);
    localparam logic [PC_WIDTH-1:0] PC_INC   = PC_WIDTH'(1);

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP  = 6'h00,
        OP_JR   = 6'h01,
        OP_JPC  = 6'h02,
        OP_BRFL = 6'h03,
        OP_CALL = 6'h04,
        OP_RET  = 6'h05
    } opcode_e;

    // NOP opcode in the low bits, every other field zero.
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR =
        {{(INSTR_WIDTH - OPCODE_WIDTH){1'b0}}, OP_NOP};

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register for a fetch response that arrives while decode is
// stalled.
//   clk_in, RST : clock, async active-low reset
//   load        : capture din (sets full)
//   unload      : entry consumed (clears full)
//   flush       : discard entry; highest priority
//   din / dout  : {instr, pc} payload
//   full        : entry holds a live response
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic         clk_in,
    input  logic         RST,
    input  logic         load,
    input  logic         unload,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full
);

    // Entry storage and occupancy flag.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            dout <= '0;
            full <= 1'b0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            dout <= din;
            full <= 1'b1;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Pipeline stage 1: PC generation and synchronous instruction-memory read,
// presenting (instr, pc_out, valid) to decode. A one-entry skid buffer absorbs
// the response in flight when decode stalls; a redirect flushes and inserts a
// single bubble.
//   clk_in, RST           : clock, async active-low reset
//   stall                 : decode cannot accept an instruction this cycle
//   branch_en, branch_pc  : redirect request and target (wins over stall)
//   imem_addr, imem_rd_en : combinational read address / strobe
//   imem_data             : read data, one cycle after the strobe
//   instr, pc_out, valid  : registered outputs to decode
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                   clk_in,
    input  logic                   RST,
    input  logic                   stall,
    input  logic                   branch_en,
    input  logic [PC_WIDTH-1:0]    branch_pc,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic                   imem_rd_en,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   valid
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_next;
    logic                inflight;
    logic [PC_WIDTH-1:0] inflight_pc;

    logic         skid_load;
    logic         skid_unload;
    logic         skid_flush;
    logic         skid_full;
    fetch_entry_t skid_din;
    fetch_entry_t skid_dout;

    // Read request: a redirect always fetches; otherwise only when decode can
    // take it and the skid entry has drained (keeps program order).
    always_comb begin
        imem_rd_en = RST & (branch_en | (~stall & ~skid_full));
        imem_addr  = branch_en ? branch_pc : pc_q;
        pc_next    = imem_addr + PC_INC;
    end

    // Skid control: park the in-flight response under stall, drain on release.
    always_comb begin
        skid_flush     = branch_en;
        skid_load      = stall & inflight;
        skid_unload    = ~stall & skid_full;
        skid_din.instr = imem_data;
        skid_din.pc    = inflight_pc;
    end

    fetch_skid_buf u_skid (
        .clk_in (clk_in),
        .RST    (RST),
        .load   (skid_load),
        .unload (skid_unload),
        .flush  (skid_flush),
        .din    (skid_din),
        .dout   (skid_dout),
        .full   (skid_full)
    );

    // PC, in-flight tracking and decode-facing output registers.
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            instr       <= NOP_INSTR;
            pc_out      <= '0;
            valid       <= 1'b0;
        end else begin
            if (imem_rd_en) begin
                pc_q        <= pc_next;
                inflight_pc <= imem_addr;
            end
            // A redirect's own read replaces any older in-flight response.
            inflight <= imem_rd_en;

            if (branch_en) begin
                valid <= 1'b0;
                instr <= NOP_INSTR;
            end else if (!stall) begin
                if (skid_full) begin
                    instr  <= skid_dout.instr;
                    pc_out <= skid_dout.pc;
                    valid  <= 1'b1;
                end else if (inflight) begin
                    instr  <= imem_data;
                    pc_out <= inflight_pc;
                    valid  <= 1'b1;
                end else begin
                    // Nothing to hand over: decode sees a NOP bubble.
                    instr <= NOP_INSTR;
                    valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed vector table covering
// free-run, stall/skid, redirect, redirect-under-stall and PC wrap, a
// hand-written reset-with-skid-full sequence, then randomized stall/redirect
// traffic checked against an in-order program-stream model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic                   clk_in = 1'b0;
    logic                   RST = 1'b0;
    logic                   stall = 1'b0;
    logic                   branch_en = 1'b0;
    logic [PC_WIDTH-1:0]    branch_pc = '0;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_rd_en;
    logic [INSTR_WIDTH-1:0] imem_data;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc_out;
    logic                   valid;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk_in     (clk_in),
        .RST        (RST),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_pc  (branch_pc),
        .imem_addr  (imem_addr),
        .imem_rd_en (imem_rd_en),
        .imem_data  (imem_data),
        .instr      (instr),
        .pc_out     (pc_out),
        .valid      (valid)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [INSTR_WIDTH-1:0] mem_word(input logic [PC_WIDTH-1:0] a);
        return 32'h1000_0000 + {16'h0000, a};
    endfunction

    // Synchronous memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk_in) begin
        if (imem_rd_en) imem_data <= mem_word(imem_addr);
        else            imem_data <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        logic                s;
        logic                b;
        logic [PC_WIDTH-1:0] bpc;
        logic                exp_rd;
        logic [PC_WIDTH-1:0] exp_addr;
        logic                exp_valid;
        logic [PC_WIDTH-1:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic b, input logic [PC_WIDTH-1:0] bpc,
                                input logic rd, input logic [PC_WIDTH-1:0] addr,
                                input logic v, input logic [PC_WIDTH-1:0] pc);
        vec_t r;
        r.s = s; r.b = b; r.bpc = bpc;
        r.exp_rd = rd; r.exp_addr = addr; r.exp_valid = v; r.exp_pc = pc;
        return r;
    endfunction

    // Called at a negedge: drive, check the strobe, clock, check outputs.
    task automatic run_vec(input vec_t v, input int idx);
        stall = v.s; branch_en = v.b; branch_pc = v.bpc;
        #1;
        check($sformatf("v%0d rd_en", idx), 32'(imem_rd_en), 32'(v.exp_rd));
        if (v.exp_rd) check($sformatf("v%0d addr", idx), 32'(imem_addr), 32'(v.exp_addr));
        @(posedge clk_in); #1;
        check($sformatf("v%0d valid", idx), 32'(valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            check($sformatf("v%0d pc", idx), 32'(pc_out), 32'(v.exp_pc));
            check($sformatf("v%0d instr", idx), instr, mem_word(v.exp_pc));
        end else begin
            check($sformatf("v%0d nop", idx), instr, NOP_INSTR);
        end
        @(negedge clk_in);
    endtask

    // Reset for a few cycles; returns at a negedge with RST released.
    task automatic do_reset();
        RST = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_pc = '0;
        repeat (2) @(negedge clk_in);
        RST = 1'b1;
    endtask

    vec_t vecs [29];

    initial begin
        logic [PC_WIDTH-1:0] exp_next;
        logic [PC_WIDTH-1:0] last_pc;
        logic                last_valid;
        int                  streak;
        logic                s;
        logic                b;
        logic [PC_WIDTH-1:0] bpc;

        // Free-run, 3-cycle stall with PC 5 in flight, redirect to 758 with
        // PC 10 in flight, redirect+stall to 1024, redirect to 65534 and wrap.
        vecs[0]  = mk(0, 0, 0,     1, 0,     0, 0);
        vecs[1]  = mk(0, 0, 0,     1, 1,     1, 0);
        vecs[2]  = mk(0, 0, 0,     1, 2,     1, 1);
        vecs[3]  = mk(0, 0, 0,     1, 3,     1, 2);
        vecs[4]  = mk(0, 0, 0,     1, 4,     1, 3);
        vecs[5]  = mk(0, 0, 0,     1, 5,     1, 4);
        vecs[6]  = mk(1, 0, 0,     0, 0,     1, 4);
        vecs[7]  = mk(1, 0, 0,     0, 0,     1, 4);
        vecs[8]  = mk(1, 0, 0,     0, 0,     1, 4);
        vecs[9]  = mk(0, 0, 0,     0, 0,     1, 5);
        vecs[10] = mk(0, 0, 0,     1, 6,     0, 0);
        vecs[11] = mk(0, 0, 0,     1, 7,     1, 6);
        vecs[12] = mk(0, 0, 0,     1, 8,     1, 7);
        vecs[13] = mk(0, 0, 0,     1, 9,     1, 8);
        vecs[14] = mk(0, 0, 0,     1, 10,    1, 9);
        vecs[15] = mk(0, 1, 758,   1, 758,   0, 0);
        vecs[16] = mk(0, 0, 0,     1, 759,   1, 758);
        vecs[17] = mk(0, 0, 0,     1, 760,   1, 759);
        vecs[18] = mk(1, 1, 1024,  1, 1024,  0, 0);
        vecs[19] = mk(1, 0, 0,     0, 0,     0, 0);
        vecs[20] = mk(1, 0, 0,     0, 0,     0, 0);
        vecs[21] = mk(0, 0, 0,     0, 0,     1, 1024);
        vecs[22] = mk(0, 0, 0,     1, 1025,  0, 0);
        vecs[23] = mk(0, 0, 0,     1, 1026,  1, 1025);
        vecs[24] = mk(0, 1, 65534, 1, 65534, 0, 0);
        vecs[25] = mk(0, 0, 0,     1, 65535, 1, 65534);
        vecs[26] = mk(0, 0, 0,     1, 0,     1, 65535);
        vecs[27] = mk(0, 0, 0,     1, 1,     1, 0);
        vecs[28] = mk(0, 0, 0,     1, 2,     1, 1);

        // Reset state.
        #2;
        check("rst valid", 32'(valid), 32'd0);
        check("rst instr", instr, NOP_INSTR);
        check("rst pc_out", 32'(pc_out), 32'd0);
        check("rst rd_en", 32'(imem_rd_en), 32'd0);

        do_reset();
        for (int i = 0; i < 29; i++) run_vec(vecs[i], i);

        // Reset mid-stream with the skid entry full (PC 2 parked).
        run_vec(mk(1, 0, 0, 0, 0, 1, 1), 29);
        #2 RST = 1'b0;
        #1;
        check("midrst valid", 32'(valid), 32'd0);
        check("midrst instr", instr, NOP_INSTR);
        check("midrst pc_out", 32'(pc_out), 32'd0);
        check("midrst rd_en", 32'(imem_rd_en), 32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        RST = 1'b1;
        run_vec(mk(0, 0, 0, 1, 0, 0, 0), 30);
        run_vec(mk(0, 0, 0, 1, 1, 1, 0), 31);
        run_vec(mk(0, 0, 0, 1, 2, 1, 1), 32);

        // Random traffic against an in-order stream model: every valid output
        // is the next PC in program order (or the redirect target), carries
        // its memory word, holds under stall, and bubbles are single.
        do_reset();
        exp_next = RESET_PC; last_pc = '0; last_valid = 1'b0; streak = 0;
        for (int c = 0; c < 3000; c++) begin
            s = ($urandom % 100) < 30;
            b = ($urandom % 100) < 8;
            bpc = ($urandom % 4 == 0) ? PC_WIDTH'(16'hFFFC + ($urandom % 4)) : PC_WIDTH'($urandom);
            stall = s; branch_en = b; branch_pc = bpc;
            #1;
            if (b) begin
                check("rnd br rd_en", 32'(imem_rd_en), 32'd1);
                check("rnd br addr", 32'(imem_addr), 32'(bpc));
            end else if (s) begin
                check("rnd stall rd_en", 32'(imem_rd_en), 32'd0);
            end
            @(posedge clk_in); #1;
            if (b) begin
                check("rnd br bubble", 32'(valid), 32'd0);
                check("rnd br nop", instr, NOP_INSTR);
                exp_next = bpc; last_valid = 1'b0; streak = 0;
            end else if (s) begin
                check("rnd hold valid", 32'(valid), 32'(last_valid));
                if (last_valid) begin
                    check("rnd hold pc", 32'(pc_out), 32'(last_pc));
                    check("rnd hold instr", instr, mem_word(last_pc));
                end else begin
                    check("rnd hold nop", instr, NOP_INSTR);
                end
                streak = 0;
            end else if (valid) begin
                check("rnd pc order", 32'(pc_out), 32'(exp_next));
                check("rnd instr", instr, mem_word(exp_next));
                last_valid = 1'b1; last_pc = exp_next;
                exp_next = exp_next + PC_INC;
                streak = 0;
            end else begin
                check("rnd bubble nop", instr, NOP_INSTR);
                streak++;
                check("rnd bubble run", 32'(streak <= 1), 32'd1);
                last_valid = 1'b0;
            end
            @(negedge clk_in);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
